// File: rtl/div_pkg.sv
// Shared types and constant helpers for the non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } type_div_state;

  function automatic int div_iters(input int width, input int unroll);
    return width / unroll;
  endfunction

  // Callers truncate to their own width.
  function automatic logic [63:0] div_most_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One combinational radix-2 non-restoring step: (A, Q, M) -> (A', Q').
module div_nr_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;

  assign shifted = {a[WIDTH-1:0], q[WIDTH-1]};
  assign a_next  = a[WIDTH] ? (shifted + m) : (shifted - m);
  assign q_next  = {q[WIDTH-2:0], ~a_next[WIDTH]};

endmodule

// File: rtl/div_nr_multi.sv
// Iterative radix-2 non-restoring divider, UNROLL quotient bits per cycle,
// with valid/ready handshakes, flush and defined zero/overflow results.
//
// state  | meaning
// S_IDLE | waiting for an operation, in_ready high
// S_DIV  | iterating (or resolving a zero-divisor/overflow case in one cycle)
// S_DONE | result held, out_valid high until out_ready
module div_nr_multi
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N = div_iters(WIDTH, UNROLL);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(div_most_neg(WIDTH));

  type_div_state state;

  logic [WIDTH:0]   a_r;
  logic [WIDTH:0]   m_r;
  logic [WIDTH-1:0] q_r;
  logic [CNT_W-1:0] cnt;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             zero_r;
  logic             ovf_r;

  logic [WIDTH:0]   a_ch [UNROLL+1];
  logic [WIDTH-1:0] q_ch [UNROLL+1];

  assign a_ch[0] = a_r;
  assign q_ch[0] = q_r;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    div_nr_step #(.WIDTH(WIDTH)) u_step (
      .a      (a_ch[i]),
      .q      (q_ch[i]),
      .m      (m_r),
      .a_next (a_ch[i+1]),
      .q_next (q_ch[i+1])
    );
  end

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             div_zero;
  logic             ovf;

  assign dvd_neg  = is_signed & dividend[WIDTH-1];
  assign dvs_neg  = is_signed & divisor[WIDTH-1];
  assign dvd_abs  = dvd_neg ? -dividend : dividend;
  assign dvs_abs  = dvs_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = is_signed & (dividend == MOST_NEG) & (divisor == '1);

  logic [WIDTH:0]   a_fin;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  assign a_fin   = a_ch[UNROLL];
  assign q_fin   = q_ch[UNROLL];
  assign rem_mag = a_fin[WIDTH] ? (a_fin[WIDTH-1:0] + m_r[WIDTH-1:0]) : a_fin[WIDTH-1:0];
  assign q_res   = neg_q_r ? -q_fin : q_fin;
  assign r_res   = neg_r_r ? -rem_mag : rem_mag;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r     <= '0;
            m_r     <= {1'b0, dvs_abs};
            // Special cases never iterate, so Q can carry the raw dividend
            // through to the zero-divisor remainder.
            q_r     <= div_zero ? dividend : dvd_abs;
            cnt     <= CNT_LAST;
            neg_q_r <= dvd_neg ^ dvs_neg;
            neg_r_r <= dvd_neg;
            zero_r  <= div_zero;
            ovf_r   <= ovf;
            state   <= S_DIV;
          end
        end
        S_DIV: begin
          if (zero_r || ovf_r) begin
            quotient    <= zero_r ? '1 : MOST_NEG;
            remainder   <= zero_r ? q_r : '0;
            div_by_zero <= zero_r;
            state       <= S_DONE;
          end else begin
            a_r <= a_fin;
            q_r <= q_fin;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              quotient    <= q_res;
              remainder   <= r_res;
              div_by_zero <= 1'b0;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nr_multi.sv
// Scoreboard bench for div_nr_multi: a 32-bit/UNROLL=1 and a 16-bit/UNROLL=4 instance.
module tb_div_nr_multi;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, is_signed, out_ready;
  logic [31:0] dividend, divisor;
  logic        in_ready, out_valid, div_by_zero;
  logic [31:0] quotient, remainder;

  logic        flush_b, in_valid_b, is_signed_b, out_ready_b;
  logic [15:0] dividend_b, divisor_b;
  logic        in_ready_b, out_valid_b, div_by_zero_b;
  logic [15:0] quotient_b, remainder_b;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  div_nr_multi #(.WIDTH(32), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  div_nr_multi #(.WIDTH(16), .UNROLL(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .is_signed(is_signed_b), .dividend(dividend_b), .divisor(divisor_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .quotient(quotient_b),
    .remainder(remainder_b), .div_by_zero(div_by_zero_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b, input int w);
    exp_t        e;
    longint      sa, sd;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    e.dz = (b == 32'd0);
    if (b == 32'd0) begin
      e.q = mask;
      e.r = a;
    end else if (s) begin
      sa = longint'({32'd0, a});
      sd = longint'({32'd0, b});
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sd = sd - (longint'(1) << w);
      e.q = 32'(sa / sd) & mask;
      e.r = 32'(sa % sd) & mask;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic run32(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input int hold, input bit scramble);
    exp_t e;
    int   lat;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    is_signed = s; dividend = a; divisor = b; in_valid = 1'b1;
    sb_q.push_back(model(s, a, b, 32));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (scramble) begin
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = ~is_signed;
      end
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    e = sb_q.pop_front();
    check({tag, "_q"}, quotient, e.q);
    check({tag, "_r"}, remainder, e.r);
    check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_q"}, quotient, e.q);
      check({tag, "_hold_r"}, remainder, e.r);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run16(input bit s, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   lat;
    int   exp_lat;
    exp_lat = (b == 16'd0 || (s && a == 16'h8000 && b == 16'hFFFF)) ? 1 : 4;
    is_signed_b = s; dividend_b = a; divisor_b = b; in_valid_b = 1'b1;
    sb_q.push_back(model(s, {16'd0, a}, {16'd0, b}, 16));
    tick();
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 50) begin
      tick();
      lat++;
    end
    check("w16_lat", 32'(lat), 32'(exp_lat));
    e = sb_q.pop_front();
    check("w16_q", {16'd0, quotient_b}, e.q);
    check("w16_r", {16'd0, remainder_b}, e.r);
    check("w16_dz", 32'(div_by_zero_b), 32'(e.dz));
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    flush_b = 1'b0; in_valid_b = 1'b0; is_signed_b = 1'b0; out_ready_b = 1'b0;
    dividend_b = '0; divisor_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);

    run32("u100_7", 1'b0, 32'd100, 32'd7, 32, 0, 1'b0);
    run32("s_m7_2", 1'b1, -32'sd7, 32'd2, 32, 0, 1'b1);
    run32("s_7_m2", 1'b1, 32'd7, -32'sd2, 32, 0, 1'b1);
    run32("s_m7_m2", 1'b1, -32'sd7, -32'sd2, 32, 0, 1'b1);
    run32("u_div0", 1'b0, 32'h1234, 32'd0, 1, 0, 1'b0);
    run32("s_div0", 1'b1, 32'h1234, 32'd0, 1, 0, 1'b0);
    run32("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1'b0);
    run32("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32, 5, 1'b0);
    run32("s_min_3", 1'b1, 32'h8000_0000, 32'd3, 32, 0, 1'b0);

    // Flush mid-iteration.
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    run32("after_flush", 1'b0, 32'd1000, 32'd33, 32, 0, 1'b0);

    // Flush together with in_valid in idle: must not be accepted.
    dividend = 32'd5; divisor = 32'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (3) tick();
    check("flush_in_valid", 32'(out_valid), 32'd0);

    // Reset mid-iteration.
    dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    check("mid_rst_dz", 32'(div_by_zero), 32'd0);

    for (int k = 0; k < 1000; k++) begin
      logic [15:0] a, b;
      bit          s;
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'd0;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(1, 7));
        3: a = 16'h8000;
        default: ;
      endcase
      s = 1'($urandom);
      run16(s, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
